video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clk_sys cycles per pixel (legal range 2..256).
REQ-002 SHALL have parameter W, default 9: width of hcount and vcount.
REQ-003 SHALL have parameters H_TOTAL 384, HB_START 258, HB_END 2, HS_START 309, HS_END 341: horizontal geometry in pixels.
REQ-004 SHALL have parameters V_TOTAL 264, VB_START 240, VB_END 16, VS_START 250, VS_END 253: vertical geometry in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0: sync active level; 0 means active-low.
REQ-006 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports h_adj and v_adj, inputs, 4 bits each: signed sync position offsets, range -8..+7.
REQ-009 SHALL have ports hcount and vcount, outputs, W bits each: current pixel and line position.
REQ-010 SHALL have ports hb and vb, outputs, 1 bit each: horizontal and vertical blank, active-high.
REQ-011 SHALL have ports hs and vs, outputs, 1 bit each: horizontal and vertical sync at SYNC_POL level.
REQ-012 SHALL have port ce_pix, output, 1 bit: pixel clock enable, pulse one clk_sys cycle wide.
REQ-013 SHALL have ports line_start and frame_start, outputs, 1 bit each: pulses one clk_sys cycle wide.

Function
REQ-014 SHALL run a divider counter 0..CLK_DIV-1 and assert ce_pix for exactly one cycle in every CLK_DIV cycles.
REQ-015 SHALL drive all outputs from registers and update hcount, vcount and all flags on the same edge that raises ce_pix; outputs SHALL hold between ce_pix pulses.
REQ-016 SHALL step hcount 0..H_TOTAL-1 and wrap to 0; on that wrap, vcount SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-017 SHALL set hb=1 when the presented hcount is >= HB_START or < HB_END, and hb=0 otherwise; vb SHALL follow the same rule with vcount, VB_START and VB_END.
REQ-018 SHALL make hs active exactly when the presented hcount lies in [HS_START+ha, HS_END+ha), where ha is the latched h_adj and the sum is taken mod H_TOTAL, so the window may wrap through 0.
REQ-019 SHALL make vs active when vcount lies in [VS_START+va, VS_END+va) mod V_TOTAL, where va is the latched v_adj; vs SHALL change only coincident with an hcount wrap.
REQ-020 SHALL latch h_adj and v_adj only on the ce_pix update that presents hcount=0 and vcount=0, so geometry never changes mid-frame.
REQ-021 SHALL pulse line_start with ce_pix when the presented hcount=0, and SHALL pulse frame_start with ce_pix when both counts are 0.
REQ-022 SHALL compute all sums at W+1 bits to avoid overflow; parameter constraints are H_TOTAL <= 2^W and V_TOTAL <= 2^W.

Reset
REQ-023 On reset, SHALL load: divider=0; hcount=H_TOTAL-1; vcount=V_TOTAL-1; hb=1; vb=1; hs and vs inactive; ce_pix=0; line_start=0; frame_start=0; latched offsets=0.
REQ-024 SHALL apply reset identically when asserted mid-line or mid-frame, with no partial pulse afterwards.
REQ-025 The first ce_pix after reset release SHALL occur CLK_DIV cycles after the first cycle with reset low, and SHALL present hcount=0, vcount=0 with frame_start=1.

Configuration
REQ-026 SHALL use macro VTG_SYNC_ADJ_EN: when defined, h_adj and v_adj behave per REQ-018 to REQ-020.
REQ-027 When VTG_SYNC_ADJ_EN is undefined, the ports SHALL remain present but be ignored, with latched offsets fixed at 0 and no adder logic synthesised.

Verification
REQ-028 Defaults, reset released -> ce_pix period is 8 cycles; frame is exactly 384*264 ce_pix; frame_start occurs once per 811008 clk_sys cycles.
REQ-029 Defaults, one line -> hb=0 for hcount 2..257 (256 pixels); hs active for 309..340; vb=0 for vcount 16..239.
REQ-030 h_adj=+7 written mid-frame -> no change in the current frame; in the next frame hs is active for 316..347.
REQ-031 HS_START=380, HS_END=4, h_adj=+7 -> hs active for hcount 3..10 across the wrap; h_adj=-8 -> hs active for 372..379.
REQ-032 Reset asserted at hcount=200, vcount=100 -> the next cycle matches REQ-023; the first ce_pix comes 8 cycles after release with frame_start=1.
REQ-033 VTG_SYNC_ADJ_EN undefined, h_adj=+5 and v_adj=-3 -> timing is identical to the zero-offset run.

Source files
------------

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: pixel enable, counters, blank/sync flags, line/frame pulses.
// Optional sync position offsets are enabled by defining VTG_SYNC_ADJ_EN.
module video_timing_gen #(
    parameter int CLK_DIV  = 8,
    parameter int W        = 9,
    parameter int H_TOTAL  = 384,
    parameter int HB_START = 258,
    parameter int HB_END   = 2,
    parameter int HS_START = 309,
    parameter int HS_END   = 341,
    parameter int V_TOTAL  = 264,
    parameter int VB_START = 240,
    parameter int VB_END   = 16,
    parameter int VS_START = 250,
    parameter int VS_END   = 253,
    parameter int SYNC_POL = 0
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [3:0]   h_adj,
    input  logic [3:0]   v_adj,
    output logic [W-1:0] hcount,
    output logic [W-1:0] vcount,
    output logic         hb,
    output logic         vb,
    output logic         hs,
    output logic         vs,
    output logic         ce_pix,
    output logic         line_start,
    output logic         frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [W-1:0]  H_MAX    = W'(H_TOTAL - 1);
    localparam logic [W-1:0]  V_MAX    = W'(V_TOTAL - 1);
    localparam logic [W:0]    H_TOT_X  = (W+1)'(H_TOTAL);
    localparam logic [W:0]    V_TOT_X  = (W+1)'(V_TOTAL);
    localparam logic [W:0]    HB_S_X   = (W+1)'(HB_START);
    localparam logic [W:0]    HB_E_X   = (W+1)'(HB_END);
    localparam logic [W:0]    VB_S_X   = (W+1)'(VB_START);
    localparam logic [W:0]    VB_E_X   = (W+1)'(VB_END);
    localparam logic [W:0]    HS_LO_C  = (W+1)'(HS_START % H_TOTAL);
    localparam logic [W:0]    HS_HI_C  = (W+1)'(HS_END % H_TOTAL);
    localparam logic [W:0]    VS_LO_C  = (W+1)'(VS_START % V_TOTAL);
    localparam logic [W:0]    VS_HI_C  = (W+1)'(VS_END % V_TOTAL);
    localparam logic          S_ACT    = (SYNC_POL != 0);

    logic [DW-1:0] div_q;
    logic          tick;
    logic          h_wrap;
    logic [W-1:0]  h_nxt;
    logic [W-1:0]  v_nxt;
    logic          frame_nxt;
    logic          hb_nxt;
    logic          vb_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic [W:0]    hs_lo;
    logic [W:0]    hs_hi;
    logic [W:0]    vs_lo;
    logic [W:0]    vs_hi;

    // Half-open window [lo, hi) on a circular count; lo > hi means it wraps through 0.
    function automatic logic in_win(input logic [W:0] x, input logic [W:0] lo, input logic [W:0] hi);
        if (lo <= hi)
            return (x >= lo) && (x < hi);
        else
            return (x >= lo) || (x < hi);
    endfunction

`ifdef VTG_SYNC_ADJ_EN
    logic [3:0] ha_q;
    logic [3:0] va_q;
    logic [3:0] ha_nxt;
    logic [3:0] va_nxt;

    // base + signed 4-bit offset, reduced mod total; base is already below total.
    function automatic logic [W:0] wrap_add(input logic [W:0] base, input logic [3:0] adj,
                                            input logic [W:0] total);
        logic [3:0] mag4;
        logic [W:0] mag;
        logic [W:0] s;
        mag4 = adj[3] ? (~adj + 4'd1) : adj;
        mag  = {{(W-3){1'b0}}, mag4};
        if (adj[3]) begin
            s = (base >= mag) ? (base - mag) : (base + total - mag);
        end else begin
            s = base + mag;
            if (s >= total)
                s = s - total;
        end
        return s;
    endfunction

    // New offsets take effect on the very update that presents the frame origin.
    always_comb begin
        ha_nxt = frame_nxt ? h_adj : ha_q;
        va_nxt = frame_nxt ? v_adj : va_q;
        hs_lo  = wrap_add(HS_LO_C, ha_nxt, H_TOT_X);
        hs_hi  = wrap_add(HS_HI_C, ha_nxt, H_TOT_X);
        vs_lo  = wrap_add(VS_LO_C, va_nxt, V_TOT_X);
        vs_hi  = wrap_add(VS_HI_C, va_nxt, V_TOT_X);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ha_q <= '0;
            va_q <= '0;
        end else if (tick && frame_nxt) begin
            ha_q <= h_adj;
            va_q <= v_adj;
        end
    end
`else
    logic unused_adj;
    assign unused_adj = ^{h_adj, v_adj};

    always_comb begin
        hs_lo = HS_LO_C;
        hs_hi = HS_HI_C;
        vs_lo = VS_LO_C;
        vs_hi = VS_HI_C;
    end
`endif

    always_comb begin
        tick      = (div_q == DIV_LAST);
        h_wrap    = (hcount == H_MAX);
        h_nxt     = h_wrap ? '0 : hcount + W'(1);
        v_nxt     = vcount;
        if (h_wrap)
            v_nxt = (vcount == V_MAX) ? '0 : vcount + W'(1);
        frame_nxt = (h_nxt == '0) && (v_nxt == '0);
        hb_nxt    = ({1'b0, h_nxt} >= HB_S_X) || ({1'b0, h_nxt} < HB_E_X);
        vb_nxt    = ({1'b0, v_nxt} >= VB_S_X) || ({1'b0, v_nxt} < VB_E_X);
        hs_nxt    = in_win({1'b0, h_nxt}, hs_lo, hs_hi) ? S_ACT : ~S_ACT;
        vs_nxt    = in_win({1'b0, v_nxt}, vs_lo, vs_hi) ? S_ACT : ~S_ACT;
    end

    // Counters start one step before the origin so the first enable presents (0,0).
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q       <= '0;
            hcount      <= H_MAX;
            vcount      <= V_MAX;
            hb          <= 1'b1;
            vb          <= 1'b1;
            hs          <= ~S_ACT;
            vs          <= ~S_ACT;
            ce_pix      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_q       <= tick ? '0 : div_q + DW'(1);
            ce_pix      <= tick;
            line_start  <= tick && (h_nxt == '0);
            frame_start <= tick && frame_nxt;
            if (tick) begin
                hcount <= h_nxt;
                vcount <= v_nxt;
                hb     <= hb_nxt;
                vb     <= vb_nxt;
                hs     <= hs_nxt;
                if (h_wrap)
                    vs <= vs_nxt;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen.
module tb_video_timing_gen;

`ifdef VTG_SYNC_ADJ_EN
    localparam int U0_HS_LO = 314;
    localparam int U2_LO_A  = 3;
    localparam int U2_LO_B  = 372;
`else
    localparam int U0_HS_LO = 309;
    localparam int U2_LO_A  = 380;
    localparam int U2_LO_B  = 380;
`endif

    logic clk;
    logic r0, r1, r2;
    logic [3:0] ha0, va0, ha1, va1, ha2, va2;
    logic [8:0] hc0, vc0, hc2, vc2;
    logic [4:0] hc1, vc1;
    logic hb0, vb0, hs0, vs0, ce0, ls0, fs0;
    logic hb1, vb1, hs1, vs1, ce1, ls1, fs1;
    logic hb2, vb2, hs2, vs2, ce2, ls2, fs2;
    logic [2:0] ce_v;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    logic hs_a [384];
    logic hb_a [384];
    logic vb_a [12];
    logic vs_a [12];

    assign ce_v = {ce2, ce1, ce0};

    video_timing_gen u0 (
        .clk_sys(clk), .reset(r0), .h_adj(ha0), .v_adj(va0),
        .hcount(hc0), .vcount(vc0), .hb(hb0), .vb(vb0), .hs(hs0), .vs(vs0),
        .ce_pix(ce0), .line_start(ls0), .frame_start(fs0)
    );

    video_timing_gen #(
        .CLK_DIV(2), .W(5), .H_TOTAL(20), .HB_START(16), .HB_END(2),
        .HS_START(17), .HS_END(19), .V_TOTAL(12), .VB_START(10), .VB_END(1),
        .VS_START(10), .VS_END(11), .SYNC_POL(1)
    ) u1 (
        .clk_sys(clk), .reset(r1), .h_adj(ha1), .v_adj(va1),
        .hcount(hc1), .vcount(vc1), .hb(hb1), .vb(vb1), .hs(hs1), .vs(vs1),
        .ce_pix(ce1), .line_start(ls1), .frame_start(fs1)
    );

    video_timing_gen #(
        .CLK_DIV(2), .HS_START(380), .HS_END(4), .V_TOTAL(4), .VB_START(3),
        .VB_END(1), .VS_START(2), .VS_END(3)
    ) u2 (
        .clk_sys(clk), .reset(r2), .h_adj(ha2), .v_adj(va2),
        .hcount(hc2), .vcount(vc2), .hb(hb2), .vb(vb2), .hs(hs2), .vs(vs2),
        .ce_pix(ce2), .line_start(ls2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ce(input int idx, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ce_v[idx] && n < limit);
        if (!ce_v[idx])
            check("ce_timeout", 32'(idx), 32'hFFFF);
    endtask

    // Record one u2 line starting at the current enable (which presents hcount 0).
    task automatic rec_line2();
        int n;
        hs_a[hc2] = hs2;
        for (int p = 1; p < 384; p++) begin
            wait_ce(2, 8, n);
            hs_a[hc2] = hs2;
        end
    endtask

    // Active-low window of 8 pixels starting at lo, wrapping mod 384.
    task automatic check_win(input string tag, input int lo);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 384; i++)
            if (hs_a[i] == 1'b0) cnt++;
        check({tag, "_cnt"}, cnt, 8);
        check({tag, "_edges"}, {hs_a[(lo + 383) % 384], hs_a[lo], hs_a[(lo + 7) % 384],
                                hs_a[(lo + 8) % 384]}, 4'b1001);
    endtask

    initial begin
        int bad_idx, cnt, tot, nce, nls, vs_bad;
        logic prev_vs;
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        ha0 = 4'd5; va0 = 4'b1101;
        ha1 = 4'd0; va1 = 4'd0;
        ha2 = 4'd7; va2 = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state and first-enable latency
        check("rst_hcount", hc0, 383);
        check("rst_vcount", vc0, 263);
        check("rst_flags", {hb0, vb0, hs0, vs0, ce0, ls0, fs0}, 7'b1111000);
        r0 = 1'b0;
        wait_ce(0, 32, cyc);
        check("first_ce_latency", cyc, 8);
        check("first_pos", {hc0, vc0}, 18'd0);
        check("first_pulses", {ls0, fs0}, 2'b11);

        // One full default line
        bad_idx = 0;
        hb_a[0] = hb0;
        hs_a[0] = hs0;
        for (int p = 1; p < 384; p++) begin
            wait_ce(0, 16, cyc);
            if (p == 1) begin
                check("ce_period", cyc, 8);
                check("mid_pulses", {ls0, fs0}, 2'b00);
            end
            if (hc0 !== 9'(p)) bad_idx++;
            hb_a[p] = hb0;
            hs_a[p] = hs0;
        end
        check("hcount_sequence", bad_idx, 0);
        cnt = 0;
        for (int i = 0; i < 384; i++)
            if (hb_a[i] == 1'b0) cnt++;
        check("hb_active_cnt", cnt, 256);
        check("hb_edges", {hb_a[1], hb_a[2], hb_a[257], hb_a[258]}, 4'b1001);
        cnt = 0;
        for (int i = 0; i < 384; i++)
            if (hs_a[i] == 1'b0) cnt++;
        check("hs_active_cnt", cnt, 32);
        check("hs_edges", {hs_a[U0_HS_LO - 1], hs_a[U0_HS_LO], hs_a[U0_HS_LO + 31],
                           hs_a[U0_HS_LO + 32]}, 4'b1001);
        wait_ce(0, 16, cyc);
        check("line1_pos", {hc0, vc0}, {9'd0, 9'd1});
        check("line1_pulses", {ls0, fs0}, 2'b10);

        // Mid-line reset
        for (int k = 0; k < 300 && hc0 !== 9'd200; k++)
            wait_ce(0, 16, cyc);
        check("reach_h200", hc0, 200);
        r0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_pos", {hc0, vc0}, {9'd383, 9'd263});
        check("midrst_flags", {hb0, vb0, hs0, vs0, ce0, ls0, fs0}, 7'b1111000);
        @(posedge clk);
        @(negedge clk);
        r0 = 1'b0;
        wait_ce(0, 32, cyc);
        check("midrst_latency", cyc, 8);
        check("midrst_first", {hc0, vc0, fs0}, 19'd1);

        // Small instance: frame length, vertical blank and sync
        r1 = 1'b0;
        wait_ce(1, 16, cyc);
        check("u1_first_fs", fs1, 1);
        vb_a[0] = vb1;
        vs_a[0] = vs1;
        prev_vs = vs1;
        tot = 0; nce = 0; nls = 0; vs_bad = 0;
        for (int k = 0; k < 300; k++) begin
            wait_ce(1, 8, cyc);
            tot += cyc;
            nce++;
            if (ls1) nls++;
            if (hc1 == 5'd0 && !fs1) begin
                vb_a[vc1] = vb1;
                vs_a[vc1] = vs1;
            end
            if (vs1 !== prev_vs && hc1 != 5'd0) vs_bad++;
            prev_vs = vs1;
            if (fs1) break;
        end
        check("u1_frame_cycles", tot, 480);
        check("u1_frame_ce", nce, 240);
        check("u1_lines", nls, 12);
        check("u1_vb_edges", {vb_a[0], vb_a[1], vb_a[9], vb_a[10]}, 4'b1001);
        cnt = 0;
        for (int i = 0; i < 12; i++)
            if (vb_a[i] == 1'b0) cnt++;
        check("u1_vb_active_cnt", cnt, 9);
        check("u1_vs_edges", {vs_a[9], vs_a[10], vs_a[11]}, 3'b010);
        check("u1_vs_off_wrap", vs_bad, 0);

        // Wrapping sync window and frame-aligned offset latch
        r2 = 1'b0;
        wait_ce(2, 16, cyc);
        check("u2_first_fs", fs2, 1);
        rec_line2();
        check_win("u2_frame1", U2_LO_A);
        ha2 = 4'b1000;
        wait_ce(2, 8, cyc);
        rec_line2();
        check_win("u2_midframe", U2_LO_A);
        for (int k = 0; k < 2000 && !fs2; k++)
            wait_ce(2, 8, cyc);
        check("u2_second_fs", fs2, 1);
        rec_line2();
        check_win("u2_frame2", U2_LO_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
